// File: rtl/lstm_seq_driver.sv
// Sequential driver for a combinational LSTM cell.
// Each accepted X sample is presented to the cell together with the recurrent
// state (c, h). The cell outputs are captured after CELL_LAT cycles and streamed
// out with valid/ready. The recurrent state is cleared at sequence end (x_last or
// step-count overflow) and by seq_clr while idle.
module lstm_seq_driver #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int CELL_LAT    = 1,
  parameter int MAX_STEPS   = 64,
  localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int WW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_seq_clr,
  input  logic                  i_x_valid,
  output logic                  o_x_ready,
  input  logic [DATA_WIDTH-1:0] i_x_data,
  input  logic                  i_x_last,
  output logic [DATA_WIDTH-1:0] o_cell_x,
  output logic [DATA_WIDTH-1:0] o_cell_c_in,
  output logic [DATA_WIDTH-1:0] o_cell_h_in,
  input  logic [DATA_WIDTH-1:0] i_cell_c_out,
  input  logic [DATA_WIDTH-1:0] i_cell_h_out,
  output logic                  o_h_valid,
  input  logic                  i_h_ready,
  output logic [DATA_WIDTH-1:0] o_h_data,
  output logic [DATA_WIDTH-1:0] o_c_data,
  output logic                  o_h_last,
  output logic [SW-1:0]         o_step_cnt,
  output logic                  o_ovf_err
);

  // The fixed-point format belongs to the cell; the driver only moves words.
  // These empty blocks flag nonsensical parameter sets in the elaborated hierarchy.
  generate
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_not_below_word
    end
    if (CELL_LAT < 1 || MAX_STEPS < 2) begin : g_bad_timing_params
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] r_h;
  logic                  r_last;
  logic [WW-1:0]         r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_h_data;
  logic [DATA_WIDTH-1:0] r_c_data;
  logic                  r_h_valid;
  logic                  r_h_last;
  logic [SW-1:0]         r_step_cnt;
  logic                  r_ovf_err;

  logic w_idle;
  logic w_accept;
  logic w_clr;
  logic w_eval_done;
  logic w_at_max;
  logic w_seq_end;
  logic w_out_take;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & i_x_valid;
  assign w_clr       = w_idle & i_seq_clr;
  assign w_eval_done = (r_state == ST_EVAL) && (r_wait_cnt == '0);
  assign w_at_max    = (r_step_cnt == SW'(MAX_STEPS - 1));
  assign w_seq_end   = r_last | w_at_max;
  assign w_out_take  = (r_state == ST_OUT) & i_h_ready;

  // Ready is suppressed while reset is held so nothing is offered mid-reset.
  assign o_x_ready   = w_idle & i_rst_n;
  assign o_cell_x    = r_x;
  assign o_cell_c_in = r_c;
  assign o_cell_h_in = r_h;
  assign o_h_valid   = r_h_valid;
  assign o_h_data    = r_h_data;
  assign o_c_data    = r_c_data;
  assign o_h_last    = r_h_last;
  assign o_step_cnt  = r_step_cnt;
  assign o_ovf_err   = r_ovf_err;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state: IDLE -> EVAL on accept, EVAL -> OUT when the hold expires,
  // OUT -> IDLE once downstream takes the result.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_x_valid)   w_state_next = ST_EVAL;
      ST_EVAL: if (w_eval_done) w_state_next = ST_OUT;
      ST_OUT:  if (i_h_ready)   w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Capture the accepted sample and arm the cell-latency hold counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_last     <= 1'b0;
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_x        <= i_x_data;
      r_last     <= i_x_last;
      r_wait_cnt <= WW'(CELL_LAT - 1);
    end else if (r_state == ST_EVAL && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - WW'(1);
    end
  end

  // Recurrent state: idle clear wins over nothing else pending; the capture
  // edge either carries the cell result forward or zeroes it at sequence end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c <= '0;
      r_h <= '0;
    end else if (w_clr) begin
      r_c <= '0;
      r_h <= '0;
    end else if (w_eval_done) begin
      r_c <= w_seq_end ? '0 : i_cell_c_out;
      r_h <= w_seq_end ? '0 : i_cell_h_out;
    end
  end

  // Output stage: load on the capture edge, hold until the handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_data  <= '0;
      r_c_data  <= '0;
      r_h_valid <= 1'b0;
      r_h_last  <= 1'b0;
    end else if (w_eval_done) begin
      r_h_data  <= i_cell_h_out;
      r_c_data  <= i_cell_c_out;
      r_h_valid <= 1'b1;
      r_h_last  <= w_seq_end;
    end else if (w_out_take) begin
      r_h_valid <= 1'b0;
      r_h_last  <= 1'b0;
    end
  end

  // Step index advances when a result leaves; wraps to 0 after a sequence end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_step_cnt <= '0;
    else if (w_clr)      r_step_cnt <= '0;
    else if (w_out_take) r_step_cnt <= r_h_last ? '0 : r_step_cnt + SW'(1);
  end

  // Sticky overflow flag: a sequence ran to MAX_STEPS without x_last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_ovf_err <= 1'b0;
    else if (w_clr)                            r_ovf_err <= 1'b0;
    else if (w_eval_done && w_at_max && !r_last) r_ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Directed bench for lstm_seq_driver with a stub cell:
// c_out = c_in + x, h_out = x + 0x0100; CELL_LAT = 1, MAX_STEPS = 4.
module tb_lstm_seq_driver;

  localparam int DW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seq_clr = 1'b0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [DW-1:0] x_data = '0;
  logic          x_last = 1'b0;
  logic [DW-1:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out;
  logic          h_valid;
  logic          h_ready = 1'b1;
  logic [DW-1:0] h_data, c_data;
  logic          h_last;
  logic [SW-1:0] step_cnt;
  logic          ovf_err;

  int checks = 0;
  int errors = 0;

  assign cell_c_out = cell_c_in + cell_x;
  assign cell_h_out = cell_x + 16'h0100;

  always #5 clk = ~clk;

  lstm_seq_driver #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LAT(1), .MAX_STEPS(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seq_clr(seq_clr),
    .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_data(x_data), .i_x_last(x_last),
    .o_cell_x(cell_x), .o_cell_c_in(cell_c_in), .o_cell_h_in(cell_h_in),
    .i_cell_c_out(cell_c_out), .i_cell_h_out(cell_h_out),
    .o_h_valid(h_valid), .i_h_ready(h_ready), .o_h_data(h_data), .o_c_data(c_data),
    .o_h_last(h_last), .o_step_cnt(step_cnt), .o_ovf_err(ovf_err)
  );

  // Runs one step with h_ready=1. Called and returns at a negedge (DUT in IDLE after).
  // clr_mode: 0 none, 1 seq_clr on the accept edge, 2 seq_clr while in EVAL.
  task automatic do_step(input logic [DW-1:0] x, input logic last, input int clr_mode,
                         output logic [DW-1:0] hd, output logic [DW-1:0] cd,
                         output logic hl, output logic [SW-1:0] sc);
    int n;
    x_valid = 1'b1; x_data = x; x_last = last;
    seq_clr = (clr_mode == 1);
    n = 0;
    while (!x_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    x_valid = 1'b0; x_last = 1'b0;
    seq_clr = (clr_mode == 2);
    n = 0;
    while (!h_valid && n < 20) begin @(negedge clk); n++; end
    seq_clr = 1'b0;
    hd = h_data; cd = c_data; hl = h_last; sc = step_cnt;
    checks++;
    if (h_valid !== 1'b1) begin
      errors++;
      $display("FAIL step_timeout x=%h: h_valid=%b required 1", x, h_valid);
    end
    $display("step x=%h last=%0d -> h_data=%h c_data=%h h_last=%0d step_cnt=%0d",
             x, last, hd, cd, hl, sc);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if (x_ready !== 1'b0) begin errors++; $display("FAIL rst_x_ready: got %b want 0", x_ready); end
    checks++;
    if ({h_valid, h_last, ovf_err, step_cnt, h_data, c_data, cell_c_in, cell_h_in, cell_x} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: hv=%b hl=%b ovf=%b sc=%0d h=%h c=%h cin=%h hin=%h x=%h want all 0",
               h_valid, h_last, ovf_err, step_cnt, h_data, c_data, cell_c_in, cell_h_in, cell_x);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", x_ready); end
  endtask

  task automatic test_sequence();
    logic [DW-1:0] hd, cd; logic hl; logic [SW-1:0] sc;
    logic [DW-1:0] exp_c [3] = '{16'd1, 16'd3, 16'd6};
    for (int i = 0; i < 3; i++) begin
      do_step(DW'(i + 1), (i == 2), 0, hd, cd, hl, sc);
      checks++;
      if (cd !== exp_c[i] || hd !== 16'h0101 + DW'(i)) begin
        errors++;
        $display("FAIL seq_data[%0d]: h=%h c=%h want h=%h c=%h", i, hd, cd, 16'h0101 + DW'(i), exp_c[i]);
      end
      checks++;
      if (hl !== (i == 2) || sc !== SW'(i)) begin
        errors++;
        $display("FAIL seq_ctrl[%0d]: h_last=%b step=%0d want h_last=%0d step=%0d", i, hl, sc, (i == 2), i);
      end
    end
    checks++;
    if (step_cnt !== '0 || cell_c_in !== '0 || cell_h_in !== '0) begin
      errors++;
      $display("FAIL seq_end_state: step=%0d c_in=%h h_in=%h want 0 0 0", step_cnt, cell_c_in, cell_h_in);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] hd, cd; logic hl; logic [SW-1:0] sc;
    h_ready = 1'b0;
    x_valid = 1'b1; x_data = 16'd5; x_last = 1'b0;
    @(negedge clk);
    x_data = 16'd7;              // next sample held valid during the stall
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (h_valid !== 1'b1 || h_data !== 16'h0105 || c_data !== 16'd5 || x_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: hv=%b h=%h c=%h xr=%b want 1 0105 0005 0",
                 i, h_valid, h_data, c_data, x_ready);
      end
      @(negedge clk);
    end
    h_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (h_valid !== 1'b0 || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: hv=%b xr=%b want 0 1", h_valid, x_ready);
    end
    @(negedge clk);              // held sample accepted on the edge just passed
    x_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (h_valid !== 1'b1 || c_data !== 16'd12 || h_data !== 16'h0107 || step_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bp_second: hv=%b h=%h c=%h step=%0d want 1 0107 000c 1", h_valid, h_data, c_data, step_cnt);
    end
    $display("step x=0007 last=0 -> h_data=%h c_data=%h (after backpressure)", h_data, c_data);
    @(negedge clk);
    do_step(16'd0, 1'b1, 0, hd, cd, hl, sc);
    checks++;
    if (cd !== 16'd12 || hl !== 1'b1 || sc !== 2'd2) begin
      errors++;
      $display("FAIL bp_close: c=%h h_last=%b step=%0d want 000c 1 2", cd, hl, sc);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] hd, cd; logic hl; logic [SW-1:0] sc;
    for (int i = 0; i < 4; i++) begin
      do_step(16'd1, 1'b0, 0, hd, cd, hl, sc);
      checks++;
      if (cd !== DW'(i + 1) || hl !== (i == 3) || sc !== SW'(i)) begin
        errors++;
        $display("FAIL ovf_step[%0d]: c=%h h_last=%b step=%0d want %0d %0d %0d", i, cd, hl, sc, i + 1, (i == 3), i);
      end
    end
    checks++;
    if (ovf_err !== 1'b1 || step_cnt !== '0) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b step=%0d want 1 0", ovf_err, step_cnt);
    end
    do_step(16'd1, 1'b1, 0, hd, cd, hl, sc);
    checks++;
    if (cd !== 16'd1 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: c=%h ovf=%b want 0001 1", cd, ovf_err);
    end
    seq_clr = 1'b1;
    @(negedge clk);
    seq_clr = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf=%b want 0", ovf_err); end
  endtask

  task automatic test_clr_same_edge();
    logic [DW-1:0] hd, cd; logic hl; logic [SW-1:0] sc;
    for (int i = 1; i <= 3; i++) do_step(DW'(i), 1'b0, 0, hd, cd, hl, sc);
    checks++;
    if (cd !== 16'd6 || step_cnt !== 2'd3) begin
      errors++;
      $display("FAIL clr_setup: c=%h step=%0d want 0006 3", cd, step_cnt);
    end
    do_step(16'd2, 1'b0, 1, hd, cd, hl, sc);
    checks++;
    if (cd !== 16'd2 || hd !== 16'h0102 || sc !== 2'd0) begin
      errors++;
      $display("FAIL clr_accept: h=%h c=%h step=%0d want 0102 0002 0", hd, cd, sc);
    end
    do_step(16'd3, 1'b0, 2, hd, cd, hl, sc);
    checks++;
    if (cd !== 16'd5 || sc !== 2'd1 || step_cnt !== 2'd2) begin
      errors++;
      $display("FAIL clr_in_eval: c=%h step_out=%0d step_now=%0d want 0005 1 2", cd, sc, step_cnt);
    end
    do_step(16'd0, 1'b1, 0, hd, cd, hl, sc);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] hd, cd; logic hl; logic [SW-1:0] sc;
    do_step(16'd4, 1'b0, 0, hd, cd, hl, sc);
    x_valid = 1'b1; x_data = 16'd9;
    @(negedge clk);
    x_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({h_valid, step_cnt, h_data, c_data, cell_c_in, cell_h_in, cell_x, x_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: hv=%b sc=%0d h=%h c=%h cin=%h hin=%h x=%h xr=%b want all 0",
               h_valid, step_cnt, h_data, c_data, cell_c_in, cell_h_in, cell_x, x_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (h_valid !== 1'b0 || x_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_drop[%0d]: hv=%b xr=%b want 0 1", i, h_valid, x_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_overflow();
    test_clr_same_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
